movement_ctrl: RTL and testbench
================================

MOVEMENT_CTRL -- requirements
Module: movement_ctrl

Interface
REQ-001 SHALL have parameter X_W, default 11, width of x position.
REQ-002 SHALL have parameter Y_W, default 11, width of y position.
REQ-003 SHALL have parameter STEP, default 5, pixels moved per step.
REQ-004 SHALL have parameters X_MIN/X_MAX, defaults 0/635, and Y_MIN/Y_MAX, defaults 0/475, as inclusive position bounds.
REQ-005 SHALL have parameters X_INIT/Y_INIT, defaults 0/0, as reset position.
REQ-006 SHALL have parameter TICK_DIV, default 2**23, clk cycles per movement tick (>=2).
REQ-007 SHALL have parameters REPEAT_DELAY, default 4, and REPEAT_RATE, default 1, both in ticks (>=1).
REQ-008 clk  input  1  system clock; all logic on rising edge; the only clock.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 up, down, left, right  input  1 each  raw asynchronous button levels.
REQ-011 en  input  1  movement enable; 0 freezes FSM, tick counter and position.
REQ-012 load  input  1  one-cycle strobe loading load_x/load_y.
REQ-013 load_x  input  X_W, load_y  input  Y_W  position to load.
REQ-014 x  output  X_W, y  output  Y_W  current registered position.
REQ-015 moved  output  1  one-cycle pulse on every position change caused by a step.
REQ-016 blocked  output  1  one-cycle pulse when a step is requested but saturation leaves position unchanged.

Function
REQ-017 Each button SHALL pass through a 2-flop synchroniser; dir = {right,left,down,up} after synchronisation.
REQ-018 Tick counter SHALL count 0..TICK_DIV-1 while en=1 and wrap; tick is 1 in the cycle the counter equals TICK_DIV-1.
REQ-019 FSM states: S_IDLE, S_DELAY, S_REPEAT; transitions evaluated only in tick cycles with en=1.
REQ-020 dir valid SHALL mean exactly one bit set; zero or multiple bits SHALL be treated as no request.
REQ-021 S_IDLE: valid dir -> step once in that direction, latch held_dir, load count=REPEAT_DELAY-1, go S_DELAY; else stay.
REQ-022 S_DELAY/S_REPEAT: dir != held_dir -> if dir valid, step in new direction, relatch, count=REPEAT_DELAY-1, go S_DELAY; else go S_IDLE.
REQ-023 S_DELAY, dir == held_dir: count>0 -> decrement; count==0 -> step, count=REPEAT_RATE-1, go S_REPEAT.
REQ-024 S_REPEAT, dir == held_dir: count>0 -> decrement; count==0 -> step, count=REPEAT_RATE-1, stay.
REQ-025 Step: up y-=STEP, down y+=STEP, left x-=STEP, right x+=STEP, computed at width+1 bits and saturated to [MIN,MAX]; no wrap-around.
REQ-026 Position SHALL update on the tick edge deciding the step; moved/blocked asserted in the following cycle, aligned with new x/y.
REQ-027 A step at a bound with partial headroom SHALL land exactly on the bound and pulse moved; zero headroom SHALL pulse blocked.
REQ-028 load SHALL override any same-cycle step, set x/y to load_x/load_y unclamped, force S_IDLE, and suppress moved/blocked; tick counter unaffected.
REQ-029 load SHALL act regardless of en.
REQ-030 Button-to-position latency SHALL be at most TICK_DIV+3 clk cycles.

Reset
REQ-031 rst SHALL set x=X_INIT, y=Y_INIT, moved=0, blocked=0, FSM=S_IDLE, tick counter=0, repeat count=0, held_dir=0, synchroniser flops=0.
REQ-032 rst SHALL take priority over load and en; reset mid-repeat SHALL produce no step in the reset cycle.

Structure
REQ-033 FSM state encoding and direction one-hot constants SHALL live in shared package tetris_pkg.
REQ-034 Tick generator SHALL be a sub-module tick_gen (parameter TICK_DIV; ports clk, rst, en, tick).
REQ-035 Position registers SHALL be the only x/y drivers; no latches, no derived clocks.

Verification (TICK_DIV=4, STEP=5, X/Y bounds 0..100, INIT 50/50, REPEAT_DELAY=3, REPEAT_RATE=1)
REQ-036 right held 1 tick then released -> x 50->55 once, one moved pulse, FSM back to S_IDLE.
REQ-037 up held 8 ticks -> y steps at ticks 1,4,5,6,7,8 -> 45,40,35,30,25,20.
REQ-038 load 98/2, then right and up held -> x 98->100 with moved, then blocked each repeat; y 2->0 likewise.
REQ-039 left+down held together -> no step, no pulses; release down -> x steps within TICK_DIV+3 cycles.
REQ-040 load asserted in a step tick cycle -> x/y equal load values, no moved; rst mid-S_REPEAT -> x/y=50/50 next cycle, FSM S_IDLE.
REQ-041 en=0 with right held 10 ticks -> x unchanged; en=1 -> first step after next tick.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared FSM encoding and button-direction constants for the movement controller.
package tetris_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  // dir = {right, left, down, up}
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  function automatic logic dir_valid(input logic [3:0] d);
    return $onehot(d);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running movement tick: pulses once every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 2 ** 23
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/movement_ctrl.sv
// Button-driven x/y position with auto-repeat, saturating bounds and load override.
module movement_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned X_W          = 11,
  parameter int unsigned Y_W          = 11,
  parameter int unsigned STEP         = 5,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 635,
  parameter int unsigned Y_MIN        = 0,
  parameter int unsigned Y_MAX        = 475,
  parameter int unsigned X_INIT       = 0,
  parameter int unsigned Y_INIT       = 0,
  parameter int unsigned TICK_DIV     = 2 ** 23,
  parameter int unsigned REPEAT_DELAY = 4,
  parameter int unsigned REPEAT_RATE  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  input  logic           en,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           moved,
  output logic           blocked
);

  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [X_W:0] XStep = (X_W + 1)'(STEP);
  localparam logic [X_W:0] XLo   = (X_W + 1)'(X_MIN);
  localparam logic [X_W:0] XHi   = (X_W + 1)'(X_MAX);
  localparam logic [Y_W:0] YStep = (Y_W + 1)'(STEP);
  localparam logic [Y_W:0] YLo   = (Y_W + 1)'(Y_MIN);
  localparam logic [Y_W:0] YHi   = (Y_W + 1)'(Y_MAX);

  logic [3:0]    sync1_q, sync2_q, dir;
  logic [3:0]    held_q, held_d, step_dir;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic          tick, step_req;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic          moved_q, moved_d, blocked_q, blocked_d;

  // One extra bit of headroom keeps the add from wrapping before the clamp.
  function automatic logic [X_W-1:0] move_x(input logic [X_W-1:0] cur, input logic neg);
    logic [X_W:0] v;
    v = {1'b0, cur};
    if (neg) v = (v < XStep) ? XLo : v - XStep;
    else     v = v + XStep;
    if (v < XLo)      v = XLo;
    else if (v > XHi) v = XHi;
    return v[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] move_y(input logic [Y_W-1:0] cur, input logic neg);
    logic [Y_W:0] v;
    v = {1'b0, cur};
    if (neg) v = (v < YStep) ? YLo : v - YStep;
    else     v = v + YStep;
    if (v < YLo)      v = YLo;
    else if (v > YHi) v = YHi;
    return v[Y_W-1:0];
  endfunction

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign dir = sync2_q;

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    cnt_d    = cnt_q;
    step_req = 1'b0;
    step_dir = held_q;
    if (tick && en) begin
      if (state_q == S_IDLE || dir != held_q) begin
        if (dir_valid(dir)) begin
          step_req = 1'b1;
          step_dir = dir;
          held_d   = dir;
          cnt_d    = CW'(REPEAT_DELAY - 1);
          state_d  = S_DELAY;
        end else begin
          state_d  = S_IDLE;
        end
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        step_req = 1'b1;
        cnt_d    = CW'(REPEAT_RATE - 1);
        state_d  = S_REPEAT;
      end
    end
    if (load) state_d = S_IDLE;
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    if (load) begin
      x_d = load_x;
      y_d = load_y;
    end else if (step_req) begin
      unique case (step_dir)
        DIR_UP:    y_d = move_y(y_q, 1'b1);
        DIR_DOWN:  y_d = move_y(y_q, 1'b0);
        DIR_LEFT:  x_d = move_x(x_q, 1'b1);
        DIR_RIGHT: x_d = move_x(x_q, 1'b0);
        default:   ;
      endcase
      moved_d   = (x_d != x_q) || (y_d != y_q);
      blocked_d = !moved_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= S_IDLE;
      held_q    <= '0;
      cnt_q     <= '0;
      x_q       <= X_W'(X_INIT);
      y_q       <= Y_W'(Y_INIT);
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      sync1_q   <= {right, left, down, up};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      held_q    <= held_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign moved   = moved_q;
  assign blocked = blocked_q;

endmodule

// File: tb/tb_movement_ctrl.sv
// Randomised bench for movement_ctrl against a hold-duration reference model.
module tb_movement_ctrl;

  localparam int TICK_DIV = 4;
  localparam int STEP     = 5;
  localparam int XMIN = 0, XMAX = 100, YMIN = 0, YMAX = 100;
  localparam int XINIT = 50, YINIT = 50;
  localparam int DELAY = 3, RATE = 1;

  logic        clk = 1'b0;
  logic        rst, up, down, left, right, en, load;
  logic [10:0] load_x, load_y;
  logic [10:0] x, y;
  logic        moved, blocked;

  always #5 clk = ~clk;

  movement_ctrl #(
    .X_W(11), .Y_W(11), .STEP(STEP),
    .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX),
    .X_INIT(XINIT), .Y_INIT(YINIT),
    .TICK_DIV(TICK_DIV), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .en(en), .load(load), .load_x(load_x), .load_y(load_y),
    .x(x), .y(y), .moved(moved), .blocked(blocked)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: position, ticks the current direction has been held,
  // enabled-cycle phase, and the two-cycle button history.
  int         mx, my, hold_n, phase;
  logic [3:0] hist0, hist1, mheld;
  logic       emoved, eblocked;
  int         n_moved, n_blocked;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_edge();
    logic [3:0] d;
    logic       do_step;
    int         nx, ny;
    d = hist1;
    emoved = 1'b0;
    eblocked = 1'b0;
    if (rst) begin
      mx = XINIT; my = YINIT; hold_n = 0; phase = 0;
      hist0 = '0; hist1 = '0; mheld = '0;
      return;
    end
    do_step = 1'b0;
    if (en && phase == TICK_DIV - 1) begin
      if ($countones(d) == 1) begin
        if (hold_n > 0 && d == mheld) hold_n++;
        else begin hold_n = 1; mheld = d; end
        do_step = (hold_n == 1) || (hold_n > DELAY && (hold_n - 1 - DELAY) % RATE == 0);
      end else begin
        hold_n = 0;
      end
    end
    if (load) begin
      mx = int'(load_x); my = int'(load_y); hold_n = 0;
    end else if (do_step) begin
      nx = mx; ny = my;
      case (mheld)
        4'b0001: ny = clampi(my - STEP, YMIN, YMAX);
        4'b0010: ny = clampi(my + STEP, YMIN, YMAX);
        4'b0100: nx = clampi(mx - STEP, XMIN, XMAX);
        default: nx = clampi(mx + STEP, XMIN, XMAX);
      endcase
      emoved = (nx != mx) || (ny != my);
      eblocked = !emoved;
      mx = nx; my = ny;
    end
    if (en) phase = (phase + 1) % TICK_DIV;
    hist1 = hist0;
    hist0 = {right, left, down, up};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("x", 32'(x), 32'(mx));
    check("y", 32'(y), 32'(my));
    check("moved", 32'(moved), 32'(emoved));
    check("blocked", 32'(blocked), 32'(eblocked));
    if (moved) n_moved++;
    if (blocked) n_blocked++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_btn(input logic [3:0] b);
    {right, left, down, up} = b;
  endtask

  task automatic do_load(input int lx, input int ly);
    load = 1'b1; load_x = 11'(lx); load_y = 11'(ly);
    cycle();
    load = 1'b0;
  endtask

  initial begin
    int x0, y0;
    bit changed;
    logic [3:0] b;
    rst = 1'b1; en = 1'b1; load = 1'b0; load_x = '0; load_y = '0;
    set_btn(4'b0000);
    mx = 0; my = 0; hold_n = 0; phase = 0; hist0 = '0; hist1 = '0; mheld = '0;
    n_moved = 0; n_blocked = 0;
    run(2);
    check("reset_x", 32'(x), 32'd50);
    check("reset_y", 32'(y), 32'd50);
    rst = 1'b0;

    // Single tap to the right
    n_moved = 0;
    set_btn(4'b1000); run(4);
    set_btn(4'b0000); run(16);
    check("tap_x", 32'(x), 32'd55);
    check("tap_pulses", 32'(n_moved), 32'd1);

    // Long hold up exercises delay then repeat
    do_load(50, 50);
    set_btn(4'b0001); run(34);
    set_btn(4'b0000); run(12);
    check("hold_up_moved", 32'(y < 11'd50), 32'd1);

    // Saturation at the bounds
    do_load(98, 2);
    n_blocked = 0;
    set_btn(4'b1000); run(30);
    check("sat_x", 32'(x), 32'd100);
    set_btn(4'b0000); run(8);
    set_btn(4'b0001); run(30);
    check("sat_y", 32'(y), 32'd0);
    check("sat_blocked", 32'(n_blocked > 4), 32'd1);
    set_btn(4'b0000); run(8);

    // Two buttons together are no request; releasing one must step promptly
    x0 = mx; y0 = my; n_moved = 0; n_blocked = 0;
    set_btn(4'b0110); run(30);
    check("multi_x", 32'(x), 32'(x0));
    check("multi_pulses", 32'(n_moved + n_blocked), 32'd0);
    set_btn(4'b0100);
    changed = 1'b0;
    for (int i = 0; i < TICK_DIV + 3 && !changed; i++) begin
      cycle();
      if (int'(x) != x0) changed = 1'b1;
    end
    check("latency", 32'(changed), 32'd1);
    set_btn(4'b0000); run(8);

    // Load landing on a step tick wins
    do_load(50, 50);
    set_btn(4'b1000); run(20);
    for (int i = 0; i < TICK_DIV && phase != TICK_DIV - 1; i++) cycle();
    do_load(10, 20);
    check("load_tick_x", 32'(x), 32'd10);
    check("load_tick_moved", 32'(moved), 32'd0);
    run(20);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rst_rep_x", 32'(x), 32'd50);
    check("rst_rep_y", 32'(y), 32'd50);
    run(10);

    // Enable low freezes everything
    en = 1'b0; x0 = mx;
    run(40);
    check("en0_x", 32'(x), 32'(x0));
    en = 1'b1; run(12);
    set_btn(4'b0000); run(8);

    // Randomised traffic, including out-of-range loads
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(2))
          0:       b = 4'b0000;
          1:       b = 4'b0001 << $urandom_range(3);
          default: b = 4'($urandom);
        endcase
        set_btn(b);
      end
      en = ($urandom_range(19) != 0);
      rst = ($urandom_range(199) == 0);
      load = ($urandom_range(49) == 0);
      load_x = ($urandom_range(9) == 0) ? 11'($urandom) : 11'($urandom_range(120));
      load_y = ($urandom_range(9) == 0) ? 11'($urandom) : 11'($urandom_range(120));
      cycle();
    end
    rst = 1'b0; load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
